// File: rtl/rng_pkg.sv
// Shared types and reference tap masks for the LFSR random-number source.
package rng_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } rng_state_t;

   // Maximal-length Fibonacci tap masks for common widths
   localparam logic [3:0]  TAPS_4  = 4'hC;
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [19:0] TAPS_20 = 20'h90000;
   localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with reseed, zero-seed substitution and lock-up recovery.
module lfsr_core
   import rng_pkg::*;
#(
   parameter int               WIDTH = 20,
   parameter logic [WIDTH-1:0] TAPS  = 20'h90000,
   parameter logic [WIDTH-1:0] SEED  = 20'h00001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next_state
);

   assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};

   // An all-zero state would never leave zero, so it is replaced by SEED on sight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else if (load) begin
         state <= (load_value == '0) ? SEED : load_value;
      end else if (state == '0) begin
         state <= SEED;
      end else if (shift) begin
         state <= next_state;
      end
   end

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random-number source: shifts SHIFTS times per sample and offers each
// sample on a valid/ready handshake.
module lfsr_rng
   import rng_pkg::*;
#(
   parameter int               WIDTH  = 20,
   parameter logic [WIDTH-1:0] TAPS   = 20'h90000,
   parameter logic [WIDTH-1:0] SEED   = 20'h00001,
   parameter int               SHIFTS = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_value,
   input  logic             rnd_ready,
   output logic             rnd_valid,
   output logic [WIDTH-1:0] random_number
);

   localparam int            CW   = $clog2(SHIFTS + 1);
   localparam logic [CW-1:0] LAST = CW'(SHIFTS - 1);

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_rng: WIDTH must be in 3..32");
   end
   if (SHIFTS < 1 || SHIFTS > 255) begin : g_bad_shifts
      $error("lfsr_rng: SHIFTS must be in 1..255");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_rng: SEED must be non-zero");
   end
   if (TAPS == '0) begin : g_bad_taps
      $error("lfsr_rng: TAPS must be non-zero");
   end

   rng_state_t       fsm;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] lfsr_state;
   logic [WIDTH-1:0] lfsr_next;
   logic             lockup;
   logic             shift;

   assign lockup = (lfsr_state == '0);
   assign shift  = (fsm == FILL) && en && !lockup && !seed_load;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .shift      (shift),
      .load       (seed_load),
      .load_value (seed_value),
      .state      (lfsr_state),
      .next_state (lfsr_next)
   );

   // A lock-up recovery cycle is not counted as a shift, so sample spacing
   // stays a whole number of real shifts after the reload
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm           <= FILL;
         cnt           <= '0;
         rnd_valid     <= 1'b0;
         random_number <= '0;
      end else if (seed_load) begin
         fsm       <= FILL;
         cnt       <= '0;
         rnd_valid <= 1'b0;
      end else begin
         case (fsm)
            FILL: begin
               if (en && !lockup) begin
                  if (cnt == LAST) begin
                     cnt           <= '0;
                     random_number <= lfsr_next;
                     rnd_valid     <= 1'b1;
                     fsm           <= HOLD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (rnd_valid && rnd_ready) begin
                  rnd_valid <= 1'b0;
                  fsm       <= FILL;
               end
            end
            default: fsm <= FILL;
         endcase
      end
   end

endmodule
